// File: rtl/mem_pkg.sv
// Shared encodings and address-decode helpers for the load/store responder
// and its load formatter.
package mem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Reserved size, unaligned word, or odd half.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic err;
    err = 1'b0;
    case (size)
      SIZE_WORD: err = (lo != 2'b00);
      SIZE_HALF: err = lo[0];
      SIZE_BYTE: err = 1'b0;
      default:   err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SIZE_WORD: be = 4'b1111;
      SIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      SIZE_BYTE: be = 4'b0001 << lo;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Extracts a byte/half/word lane from a little-endian word and sign- or
// zero-extends it to 32 bits. Also used by the cache refill path.
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{lo, 3'b000} +: 8];
    lane_h = lo[1] ? word[31:16] : word[15:0];
    data   = 32'h0;
    case (size)
      SIZE_WORD: data = word;
      SIZE_HALF: data = {{16{sign & lane_h[15]}}, lane_h};
      SIZE_BYTE: data = {{24{sign & lane_b[7]}}, lane_b};
      default:   data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder: one request at a time, stores commit at
// acceptance, loads are read on the edge entering RESP, fixed LATENCY.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSign,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] RespRData,
  output logic        RespErr
);

  localparam int         AW       = $clog2(MEM_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e          state;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx_p0;
  logic [1:0]      lo_p0;
  logic [1:0]      size_p0;
  logic            sign_p0;
  logic            write_p0;
  logic            err_p0;
  logic [31:0]     mem [MEM_WORDS];

  logic            accept;
  logic            req_err;
  logic [AW-1:0]   req_idx;
  logic [3:0]      req_be;
  logic [31:0]     req_lanes;
  logic            enter_resp;
  logic [31:0]     fmt_data;
  logic            unused_addr;

  assign ReqReady    = rst_n && (state == IDLE);
  assign RespValid   = (state == RESP);
  assign accept      = ReqValid && ReqReady;
  assign req_err     = misaligned(ReqSize, ReqAddr[1:0]);
  assign req_idx     = ReqAddr[AW+1:2];
  assign req_be      = byte_en(ReqSize, ReqAddr[1:0]);
  assign enter_resp  = (state == WAIT) && (cnt == 4'd0);
  // Upper address bits alias onto the array.
  assign unused_addr = ^ReqAddr[31:AW+2];

  // Right-aligned store data replicated so every enabled lane sees its bytes.
  always_comb begin
    case (ReqSize)
      SIZE_HALF: req_lanes = {2{ReqWData[15:0]}};
      SIZE_BYTE: req_lanes = {4{ReqWData[7:0]}};
      default:   req_lanes = ReqWData;
    endcase
  end

  load_formatter u_fmt (
    .word (mem[idx_p0]),
    .lo   (lo_p0),
    .size (size_p0),
    .sign (sign_p0),
    .data (fmt_data)
  );

  // Control: FSM, latency counter and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      RespRData <= 32'h0;
      RespErr   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= WAIT;
          cnt   <= CNT_INIT;
        end
        WAIT: begin
          if (enter_resp) begin
            state     <= RESP;
            RespRData <= (write_p0 || err_p0) ? 32'h0 : fmt_data;
            RespErr   <= err_p0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: if (RespReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Captured request fields.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_p0   <= req_idx;
      lo_p0    <= ReqAddr[1:0];
      size_p0  <= ReqSize;
      sign_p0  <= ReqSign;
      write_p0 <= ReqWrite;
      err_p0   <= req_err;
    end
  end

  // Array write at the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && ReqWrite && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) mem[req_idx][8*i +: 8] <= req_lanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: instance 0 with LATENCY=2,
// instance 1 with LATENCY=1 for the short-latency and wrap-around cases.
module tb_data_mem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_write, req_sign;
  logic [1:0]  resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [31:0] resp_rdata [2];
  logic [1:0]  req_size [2];

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.MEM_WORDS(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(req_valid[0]), .ReqReady(req_ready[0]), .ReqWrite(req_write[0]),
    .ReqAddr(req_addr[0]), .ReqWData(req_wdata[0]), .ReqSize(req_size[0]),
    .ReqSign(req_sign[0]), .RespValid(resp_valid[0]), .RespReady(resp_ready[0]),
    .RespRData(resp_rdata[0]), .RespErr(resp_err[0])
  );

  data_mem_responder #(.MEM_WORDS(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(req_valid[1]), .ReqReady(req_ready[1]), .ReqWrite(req_write[1]),
    .ReqAddr(req_addr[1]), .ReqWData(req_wdata[1]), .ReqSize(req_size[1]),
    .ReqSign(req_sign[1]), .RespValid(resp_valid[1]), .RespReady(resp_ready[1]),
    .RespRData(resp_rdata[1]), .RespErr(resp_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One full transaction: handshake in, bounded wait for the response,
  // latency check, handshake out, check return to IDLE.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size,
                      input logic sgn, input int lat,
                      output logic [31:0] rdata, output logic err);
    int k;
    @(negedge clk);
    chk("ready_idle", 32'(req_ready[d]), 32'h1);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_size[d]  = size;
    req_sign[d]  = sgn;
    @(negedge clk);
    req_valid[d] = 1'b0;
    chk("ready_busy", 32'(req_ready[d]), 32'h0);
    k = 0;
    while (!resp_valid[d] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(lat));
    rdata = resp_rdata[d];
    err   = resp_err[d];
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    chk("back_idle", {30'h0, resp_valid[d], req_ready[d]}, 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;

    req_valid = '0; req_write = '0; req_sign = '0; resp_ready = '0;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = '0; req_wdata[i] = '0; req_size[i] = SIZE_WORD;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready[0]), 32'h0);
    chk("rst_valid", 32'(resp_valid[0]), 32'h0);
    chk("rst_rdata", resp_rdata[0], 32'h0);
    chk("rst_err", 32'(resp_err[0]), 32'h0);
    chk("rst_valid_l1", 32'(resp_valid[1]), 32'h0);
    rst_n = 1'b1;

    // Word store then word load.
    xfer(0, 1'b1, 32'h10, 32'h11223344, SIZE_WORD, 1'b0, 2, rd, er);
    chk("st_w_rdata", rd, 32'h0);
    chk("st_w_err", 32'(er), 32'h0);
    xfer(0, 1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0, 2, rd, er);
    chk("ld_w_rdata", rd, 32'h11223344);
    chk("ld_w_err", 32'(er), 32'h0);

    // Byte store, signed/unsigned byte load, word view.
    xfer(0, 1'b1, 32'h13, 32'h000000AB, SIZE_BYTE, 1'b0, 2, rd, er);
    chk("st_b_err", 32'(er), 32'h0);
    xfer(0, 1'b0, 32'h13, 32'h0, SIZE_BYTE, 1'b1, 2, rd, er);
    chk("ld_b_sign", rd, 32'hFFFFFFAB);
    xfer(0, 1'b0, 32'h13, 32'h0, SIZE_BYTE, 1'b0, 2, rd, er);
    chk("ld_b_zero", rd, 32'h000000AB);
    xfer(0, 1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0, 2, rd, er);
    chk("ld_w_merged", rd, 32'hAB223344);

    // Half store into upper lanes of a known word.
    xfer(0, 1'b1, 32'h20, 32'h55667788, SIZE_WORD, 1'b0, 2, rd, er);
    xfer(0, 1'b1, 32'h22, 32'h00008001, SIZE_HALF, 1'b0, 2, rd, er);
    chk("st_h_err", 32'(er), 32'h0);
    xfer(0, 1'b0, 32'h22, 32'h0, SIZE_HALF, 1'b1, 2, rd, er);
    chk("ld_h_sign", rd, 32'hFFFF8001);
    xfer(0, 1'b0, 32'h20, 32'h0, SIZE_WORD, 1'b0, 2, rd, er);
    chk("ld_w_half", rd, 32'h80017788);

    // Error cases must not touch the array.
    xfer(0, 1'b0, 32'h21, 32'h0, SIZE_WORD, 1'b0, 2, rd, er);
    chk("mis_w_err", 32'(er), 32'h1);
    chk("mis_w_rdata", rd, 32'h0);
    xfer(0, 1'b1, 32'h23, 32'h0000FFFF, SIZE_HALF, 1'b0, 2, rd, er);
    chk("mis_h_err", 32'(er), 32'h1);
    chk("mis_h_rdata", rd, 32'h0);
    xfer(0, 1'b1, 32'h20, 32'hFFFFFFFF, 2'b11, 1'b0, 2, rd, er);
    chk("rsv_err", 32'(er), 32'h1);
    chk("rsv_rdata", rd, 32'h0);
    xfer(0, 1'b0, 32'h20, 32'h0, SIZE_WORD, 1'b0, 2, rd, er);
    chk("err_no_write", rd, 32'h80017788);
    chk("err_clear", 32'(er), 32'h0);

    // Stall in RESP with a pending extra request that must be ignored.
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10; req_size[0] = SIZE_WORD;
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall_enter", 32'(resp_valid[0]), 32'h1);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_wdata[0] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(resp_valid[0]), 32'h1);
      chk("stall_rdata", resp_rdata[0], 32'hAB223344);
      chk("stall_ready", 32'(req_ready[0]), 32'h0);
    end
    resp_ready[0] = 1'b1;
    req_valid[0]  = 1'b0;
    @(negedge clk);
    resp_ready[0] = 1'b0;
    chk("stall_release", {30'h0, resp_valid[0], req_ready[0]}, 32'h1);
    xfer(0, 1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0, 2, rd, er);
    chk("stall_no_store", rd, 32'hAB223344);

    // Reset during WAIT of a load.
    xfer(0, 1'b1, 32'h40, 32'hCAFEF00D, SIZE_WORD, 1'b0, 2, rd, er);
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h40; req_size[0] = SIZE_WORD;
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_valid", 32'(resp_valid[0]), 32'h0);
      chk("midrst_ready", 32'(req_ready[0]), 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle", {30'h0, resp_valid[0], req_ready[0]}, 32'h1);
    xfer(0, 1'b0, 32'h40, 32'h0, SIZE_WORD, 1'b0, 2, rd, er);
    chk("midrst_reload", rd, 32'hCAFEF00D);

    // LATENCY = 1 and address wrap-around at 4 KiB.
    xfer(1, 1'b1, 32'h1000, 32'hDEADBEEF, SIZE_WORD, 1'b0, 1, rd, er);
    chk("l1_st_err", 32'(er), 32'h0);
    xfer(1, 1'b0, 32'h0, 32'h0, SIZE_WORD, 1'b0, 1, rd, er);
    chk("wrap_word", rd, 32'hDEADBEEF);
    xfer(1, 1'b0, 32'h1002, 32'h0, SIZE_HALF, 1'b0, 1, rd, er);
    chk("wrap_half", rd, 32'h0000DEAD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
